// File: rtl/alu_exec_unit.sv
// alu_exec_unit: WIDTH-generic EX-stage ALU with iterative MULTU and, when ALU_DIVU_EN
// is defined, iterative restoring DIVU; both write Hi/Lo only at FIN.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR = 6'd37;
    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_SLT = 6'd42;
    localparam logic [5:0] F_SLL = 6'd0;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;
`ifdef ALU_DIVU_EN
    localparam logic [5:0] F_DIVU = 6'd27;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   rv_q, rv_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [WIDTH-1:0]       alu_res;
    logic [WIDTH:0]         mul_sum;

    assign busy = state_q != IDLE;
    assign result = result_q;
    assign result_valid = rv_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

    // acc holds {partial product, unconsumed multiplier bits}; one bit retires per cycle
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opb_q : {WIDTH{1'b0}}};

`ifdef ALU_DIVU_EN
    logic [WIDTH:0] div_top, div_diff;
    // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign div_top = acc_q[2*WIDTH-2:WIDTH-1];
    assign div_diff = div_top - {1'b0, opb_q};
`endif

    always_comb begin
        alu_res = '0;
        case (funct)
            F_AND:   alu_res = data_a & data_b;
            F_OR:    alu_res = data_a | data_b;
            F_ADD:   alu_res = data_a + data_b;
            F_SUB:   alu_res = data_a - data_b;
            F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(data_b)};
            F_SLL:   alu_res = data_a << data_b[SHAMT_W-1:0];
            F_MFHI:  alu_res = hi_q;
            F_MFLO:  alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        opb_d = opb_q;
        result_d = result_q;
        rv_d = 1'b0;
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (funct == F_MULTU) begin
                        state_d = MUL;
                        cnt_d = CNT_INIT;
                        acc_d = {{WIDTH{1'b0}}, data_b};
                        opb_d = data_a;
                    end
`ifdef ALU_DIVU_EN
                    else if (funct == F_DIVU) begin
                        state_d = DIV;
                        cnt_d = CNT_INIT;
                        acc_d = {{WIDTH{1'b0}}, data_a};
                        opb_d = data_b;
                    end
`endif
                    else begin
                        result_d = alu_res;
                        rv_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_ONE;
                state_d = (cnt_q == CNT_ONE) ? FIN : MUL;
            end
`ifdef ALU_DIVU_EN
            // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend
            DIV: begin
                acc_d = div_diff[WIDTH] ? {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d = cnt_q - CNT_ONE;
                state_d = (cnt_q == CNT_ONE) ? FIN : DIV;
            end
`endif
            FIN: begin
                hi_d = acc_q[2*WIDTH-1:WIDTH];
                lo_d = acc_q[WIDTH-1:0];
                result_d = acc_q[WIDTH-1:0];
                rv_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            opb_q <= '0;
            result_q <= '0;
            rv_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opb_q <= opb_d;
            result_q <= result_d;
            rv_q <= rv_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
endmodule
